// File: rtl/jesd204b_pkg.sv
// rtl/jesd204b_pkg.sv - JESD204B DLL shared constants, state encoding and helpers
package jesd204b_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;   // /K/ code group synchronisation
   localparam logic [7:0] K28_0 = 8'h1C;   // /R/ multiframe start in ILAS
   localparam logic [7:0] K28_3 = 8'h7C;   // /A/ multiframe end
   localparam logic [7:0] K28_4 = 8'h9C;   // /Q/ marks the config multiframe
   localparam logic [7:0] K28_7 = 8'hFC;   // /F/ frame end

   localparam int ILAS_MF_COUNT = 4;
   localparam int CFG_LEN       = 14;

   localparam logic [14:0] SCR_SEED = 15'h7F80;

   typedef enum logic [1:0] {
      ST_CGS  = 2'd0,
      ST_ILAS = 2'd1,
      ST_DATA = 2'd2
   } dll_state_t;

   // Config octet idx (0..13); octet 0 sits in the top byte of the vector
   function automatic logic [7:0] cfg_octet(input logic [8*CFG_LEN-1:0] cfg, input int idx);
      return cfg[8*(CFG_LEN-1-idx) +: 8];
   endfunction

endpackage

// File: rtl/jesd204b_scrambler.sv
// rtl/jesd204b_scrambler.sv - combinational 1+x^14+x^15 self-synchronous scrambler, one frame per call
module jesd204b_scrambler
   import jesd204b_pkg::*;
#(
   parameter int OCTETS = 4
) (
   input  logic [8*OCTETS-1:0] data_in,
   input  logic [14:0]         state_in,
   input  logic                load,
   output logic [8*OCTETS-1:0] data_out,
   output logic [14:0]         state_out
);

   logic [14:0] st;
   logic        sbit;

   // Walk bus MSB first (octet 0 first); st[0] is the newest scrambled bit, st[14] the oldest
   always_comb begin
      st       = load ? SCR_SEED : state_in;
      sbit     = 1'b0;
      data_out = '0;
      for (int b = 8*OCTETS-1; b >= 0; b--) begin
         sbit        = data_in[b] ^ st[13] ^ st[14];
         data_out[b] = sbit;
         st          = {st[13:0], sbit};
      end
      state_out = st;
   end

endmodule

// File: rtl/jesd204b_dll_tx.sv
// rtl/jesd204b_dll_tx.sv - per-lane JESD204B TX data link layer (CGS/ILAS/DATA); option macro JESD204B_DLL_SCRAMBLE_EN
module jesd204b_dll_tx
   import jesd204b_pkg::*;
#(
   parameter int OCTETS        = 4,
   parameter int FRAMES_PER_MF = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sync_n,
   input  logic [8*OCTETS-1:0] tx_datain,
   input  logic [111:0]        cfg_octets,
   output logic                tx_ready,
   output logic [8*OCTETS-1:0] tx_dataout,
   output logic [OCTETS-1:0]   tx_charisk,
   output logic                lmfc_edge
);

   localparam int              W      = 8*OCTETS;
   localparam int              FCW    = (FRAMES_PER_MF > 1) ? $clog2(FRAMES_PER_MF) : 1;
   localparam logic [FCW-1:0]  FC_LAST = FCW'(FRAMES_PER_MF-1);
   localparam logic [31:0]     P_LAST  = 32'(OCTETS*FRAMES_PER_MF-1);
   localparam logic [1:0]      MF_LAST = 2'(ILAS_MF_COUNT-1);

   dll_state_t     state;
   logic [FCW-1:0] frame_cnt;
   logic [1:0]     mf_cnt;
   logic           prev_valid;

   logic [W-1:0]      ilas_word;
   logic [OCTETS-1:0] ilas_k;
   logic [W-1:0]      data_word;
   logic [OCTETS-1:0] data_k;

   // ILAS octet generator: /R/ at p=0, /A/ at last p, /Q/+config in mf 1, ramp elsewhere
   always_comb begin
      logic [31:0] p;
      logic [7:0]  oct;
      logic        kf;
      ilas_word = '0;
      ilas_k    = '0;
      for (int i = 0; i < OCTETS; i++) begin
         p   = 32'(frame_cnt) * 32'(OCTETS) + 32'(i);
         oct = p[7:0];
         kf  = 1'b0;
         if (p == 32'd0) begin
            oct = K28_0;
            kf  = 1'b1;
         end else if (p == P_LAST) begin
            oct = K28_3;
            kf  = 1'b1;
         end else if (mf_cnt == 2'd1 && p == 32'd1) begin
            oct = K28_4;
            kf  = 1'b1;
         end else if (mf_cnt == 2'd1 && p >= 32'd2 && p <= 32'(CFG_LEN+1)) begin
            oct = cfg_octet(cfg_octets, int'(p) - 2);
         end
         ilas_word[W-1-8*i -: 8] = oct;
         ilas_k[OCTETS-1-i]      = kf;
      end
   end

`ifdef JESD204B_DLL_SCRAMBLE_EN
   logic [14:0] scr_state;
   logic [14:0] scr_next;
   logic [W-1:0] scr_data;

   // Scrambler state reloads from the seed on the first DATA frame (prev_valid still low)
   jesd204b_scrambler #(.OCTETS(OCTETS)) u_scrambler (
      .data_in   (tx_datain),
      .state_in  (scr_state),
      .load      (!prev_valid),
      .data_out  (scr_data),
      .state_out (scr_next)
   );

   // Replacement decided on the scrambled last octet; value stays, only the K flag is raised
   always_comb begin
      data_word = scr_data;
      data_k    = '0;
      if ((scr_data[7:0] == K28_3 && frame_cnt == FC_LAST) || scr_data[7:0] == K28_7)
         data_k[0] = 1'b1;
   end
`else
   logic [7:0] prev_last;

   // Replacement of the frame-end octet when it repeats the previous frame's last octet
   always_comb begin
      data_word = tx_datain;
      data_k    = '0;
      if (prev_valid && tx_datain[7:0] == prev_last) begin
         data_word[7:0] = (frame_cnt == FC_LAST) ? K28_3 : K28_7;
         data_k[0]      = 1'b1;
      end
   end
`endif

   // Link state machine, LMFC counter and registered lane outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_CGS;
         frame_cnt  <= '0;
         mf_cnt     <= '0;
         prev_valid <= 1'b0;
         tx_ready   <= 1'b0;
         tx_dataout <= '0;
         tx_charisk <= '0;
         lmfc_edge  <= 1'b0;
`ifdef JESD204B_DLL_SCRAMBLE_EN
         scr_state  <= SCR_SEED;
`else
         prev_last  <= '0;
`endif
      end else begin
         frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FCW'(1);
         lmfc_edge <= (frame_cnt == FC_LAST);
         case (state)
            ST_CGS: begin
               tx_dataout <= {OCTETS{K28_5}};
               tx_charisk <= '1;
               tx_ready   <= 1'b0;
               prev_valid <= 1'b0;
               if (sync_n && frame_cnt == FC_LAST) begin
                  state  <= ST_ILAS;
                  mf_cnt <= '0;
               end
            end
            ST_ILAS: begin
               prev_valid <= 1'b0;
               if (!sync_n) begin
                  state      <= ST_CGS;
                  tx_dataout <= {OCTETS{K28_5}};
                  tx_charisk <= '1;
                  tx_ready   <= 1'b0;
               end else begin
                  tx_dataout <= ilas_word;
                  tx_charisk <= ilas_k;
                  if (frame_cnt == FC_LAST) begin
                     mf_cnt <= mf_cnt + 2'd1;
                     if (mf_cnt == MF_LAST) begin
                        state    <= ST_DATA;
                        tx_ready <= 1'b1;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (!sync_n) begin
                  state      <= ST_CGS;
                  tx_dataout <= {OCTETS{K28_5}};
                  tx_charisk <= '1;
                  tx_ready   <= 1'b0;
                  prev_valid <= 1'b0;
               end else begin
                  tx_dataout <= data_word;
                  tx_charisk <= data_k;
                  tx_ready   <= 1'b1;
                  prev_valid <= 1'b1;
`ifdef JESD204B_DLL_SCRAMBLE_EN
                  scr_state  <= scr_next;
`else
                  prev_last  <= tx_datain[7:0];
`endif
               end
            end
            default: begin
               state      <= ST_CGS;
               tx_ready   <= 1'b0;
               prev_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
